// File: rtl/sap_program_loader.sv
// sap_program_loader: fills SAP RAM from a byte stream while holding the CPU; define SAP_LOADER_VERIFY_EN for readback verify.
module sap_program_loader #(
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  input  logic [DATA_W-1:0] bus_in,
  output logic              maddr_latch,
  output logic              ram_latch,
  output logic              ram_out,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] checksum,
  output logic              verify_err
);
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, ADDR, DATA, VADDR, VREAD, DONE} state_t;
  state_t state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] byte_q;
  logic last, hs, clear;
  assign last  = addr == ADDR_W'(MEM_DEPTH - 1);
  assign hs    = in_ready & in_valid;
  assign clear = state == IDLE && start;
  always_comb begin
    next_state = state;
    if (state != IDLE && abort) next_state = IDLE;
    else
      case (state)
        IDLE:      next_state = start ? WAIT_BYTE : IDLE;
        WAIT_BYTE: next_state = in_valid ? ADDR : WAIT_BYTE;
        ADDR:      next_state = DATA;
`ifdef SAP_LOADER_VERIFY_EN
        DATA:      next_state = last ? VADDR : WAIT_BYTE;
        VADDR:     next_state = VREAD;
        VREAD:     next_state = last ? DONE : VADDR;
`else
        DATA:      next_state = last ? DONE : WAIT_BYTE;
`endif
        default:   next_state = IDLE;
      endcase
  end
  assign in_ready    = state == WAIT_BYTE && !abort;
  assign maddr_latch = state == ADDR || state == VADDR;
  assign ram_latch   = state == DATA;
  assign bus_drive   = state == ADDR || state == DATA || state == VADDR;
  assign bus_out     = state == DATA ? byte_q : maddr_latch ? DATA_W'(addr) : '0;
  assign cpu_hold    = state != IDLE;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      byte_q   <= '0;
      count    <= '0;
      checksum <= '0;
    end else begin
      state <= next_state;
      if (clear) begin
        addr     <= '0;
        count    <= '0;
        checksum <= '0;
      end
      if (hs) begin
        byte_q   <= in_data;
        checksum <= checksum + in_data;
      end
      if (state == DATA) begin
        count <= count + 1'b1;
        addr  <= addr + 1'b1;
      end
`ifdef SAP_LOADER_VERIFY_EN
      if (state == VREAD) addr <= addr + 1'b1;
`endif
    end
`ifdef SAP_LOADER_VERIFY_EN
  logic [DATA_W-1:0] rsum, rsum_next;
  assign ram_out   = state == VREAD;
  assign rsum_next = rsum + bus_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rsum       <= '0;
      verify_err <= 1'b0;
    end else if (clear) begin
      rsum       <= '0;
      verify_err <= 1'b0;
    end else if (state == VREAD) begin
      rsum <= rsum_next;
      if (last && !abort && rsum_next != checksum) verify_err <= 1'b1;
    end
`else
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
  assign ram_out       = 1'b0;
  assign verify_err    = 1'b0;
`endif
endmodule

// File: tb/tb_sap_program_loader.sv
// tb_sap_program_loader: scoreboard bench for the SAP program loader with a small RAM/MAR model on the W bus.
module tb_sap_program_loader;
  logic clk = 0, reset = 1, start = 0, abort = 0, in_valid = 0;
  logic [7:0] in_data = 0, bus_in, bus_out, checksum;
  logic in_ready, bus_drive, maddr_latch, ram_latch, ram_out, cpu_hold, busy, done, verify_err;
  logic [4:0] count;
  sap_program_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bus_out(bus_out), .bus_drive(bus_drive), .bus_in(bus_in),
    .maddr_latch(maddr_latch), .ram_latch(ram_latch), .ram_out(ram_out), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .count(count), .checksum(checksum), .verify_err(verify_err)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [16];
  logic [3:0] mar = 0;
  logic corrupt = 0;
  always @(posedge clk) begin
    if (maddr_latch) mar <= bus_out[3:0];
    if (ram_latch) mem[mar] <= bus_out;
  end
  assign bus_in = ram_out ? mem[mar] + ((corrupt && mar == 4'd3) ? 8'd1 : 8'd0) : 8'h00;
  typedef struct packed {logic [1:0] kind; logic [7:0] val; logic [4:0] cnt; logic verr;} exp_t;
  exp_t sb [$];
  exp_t e;
  int k;
  int checks = 0, errors = 0;
  logic [3:0] exp_addr = 0;
  logic prev_done = 0;
  logic [7:0] vec [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  // kind 0: MAR latch with address, 1: RAM write with data, 2: done with totals
  always @(negedge clk)
    if (reset) prev_done = 0;
    else begin
      if (maddr_latch | ram_latch | ram_out) chk("strobe_onehot", $countones({maddr_latch, ram_latch, ram_out}), 1);
      if (ram_out) chk("drive_vs_ram_out", bus_drive, 0);
      if (in_ready) chk("quiet_in_wait", {maddr_latch, ram_latch, bus_drive}, 0);
      if (prev_done) chk("hold_after_done", {cpu_hold, busy}, 0);
      prev_done = done;
      if (maddr_latch | ram_latch | done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got maddr=%b ram=%b done=%b want none", maddr_latch, ram_latch, done);
        end else begin
          e = sb.pop_front();
          k = maddr_latch ? 0 : ram_latch ? 1 : 2;
          chk("event_kind", k, e.kind);
          if (k < 2) chk(k == 0 ? "addr_bus" : "data_bus", bus_out, e.val);
          else begin
            chk("done_count", count, e.cnt);
            chk("done_checksum", checksum, e.val);
            chk("done_verify_err", verify_err, e.verr);
            chk("done_hold", cpu_hold, 1);
          end
        end
      end
    end
  task automatic wait_ready;
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready got 0 want 1");
    end
  endtask
  task automatic do_start;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    exp_addr = 0;
    chk("start_to_ready", in_ready, 1);
  endtask
  task automatic send_byte(input logic [7:0] d, input int gap, input logic pulse_start);
    in_valid = 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    if (pulse_start) begin
      wait_ready();
      start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    in_valid = 1;
    in_data = d;
    wait_ready();
    sb.push_back('{2'd0, {4'h0, exp_addr}, 5'd0, 1'b0});
    sb.push_back('{2'd1, d, 5'd0, 1'b0});
    @(posedge clk); #1;
    in_valid = 0;
    exp_addr++;
  endtask
  task automatic finish_load(input logic [7:0] cks, input logic verr);
    int n = 0;
`ifdef SAP_LOADER_VERIFY_EN
    for (int i = 0; i < 16; i++) sb.push_back('{2'd0, 8'(i), 5'd0, 1'b0});
`endif
    sb.push_back('{2'd2, cks, 5'd16, verr});
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done got 0 want 1");
    end
    @(posedge clk); #1;
    chk("count_hold", count, 16);
    chk("checksum_hold", checksum, cks);
  endtask
  task automatic load(input int gap_max, input logic [7:0] cks, input logic verr, input int pulse_at);
    do_start();
    for (int i = 0; i < 16; i++) send_byte(vec[i], $urandom_range(gap_max, 0), i == pulse_at);
    finish_load(cks, verr);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) vec[i] = 8'(i + 1);
    repeat (2) @(posedge clk); #1;
    chk("reset_strobes", {in_ready, bus_drive, maddr_latch, ram_latch, ram_out, cpu_hold, busy, done, verify_err}, 0);
    chk("reset_bus_out", bus_out, 0);
    chk("reset_count", count, 0);
    chk("reset_checksum", checksum, 0);
    reset = 0;
    @(posedge clk); #1;
    load(0, 8'h88, 1'b0, -1);
    load(5, 8'h88, 1'b0, -1);
    do_start();
    for (int i = 0; i < 5; i++) send_byte(vec[i], 0, 1'b0);
    wait_ready();
    in_valid = 1;
    in_data = 8'h06;
    abort = 1;
    #1 chk("abort_gates_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 0;
    abort = 0;
    chk("abort_idle", {busy, cpu_hold}, 0);
    chk("abort_count", count, 5);
    chk("abort_checksum", checksum, 8'h0F);
    repeat (3) @(posedge clk); #1;
    do_start();
    for (int i = 0; i < 8; i++) send_byte(vec[i], 0, 1'b0);
    wait_ready();
    in_valid = 1;
    in_data = vec[8];
    sb.push_back('{2'd0, 8'h08, 5'd0, 1'b0});
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("in_data_state", ram_latch, 1);
    reset = 1;
    #1;
    chk("async_reset_strobes", {in_ready, bus_drive, maddr_latch, ram_latch, ram_out, cpu_hold, busy, done}, 0);
    chk("async_reset_bus", bus_out, 0);
    chk("async_reset_count", count, 0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 16; i++) vec[i] = 8'(i * 17);
    load(2, 8'hF8, 1'b0, 2);
`ifdef SAP_LOADER_VERIFY_EN
    for (int i = 0; i < 16; i++) vec[i] = 8'(i + 1);
    load(0, 8'h88, 1'b0, -1);
    corrupt = 1;
    load(0, 8'h88, 1'b1, -1);
    chk("verify_err_sticky", verify_err, 1);
    do_start();
    chk("verify_err_cleared", verify_err, 0);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    corrupt = 0;
`endif
    repeat (2) @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
